// File: rtl/ae18_pkg.sv
// Shared ae18 definitions: stack controller state encodings.
package ae18_pkg;

   localparam logic [0:0] AE18_ST_IDLE  = 1'b0;
   localparam logic [0:0] AE18_ST_POPRD = 1'b1;

   typedef enum logic [0:0] {
      StIdle  = AE18_ST_IDLE,
      StPopRd = AE18_ST_POPRD
   } ae18_stack_state_e;

endpackage : ae18_pkg

// File: rtl/ae18_sram.sv
// Simple dual-port RAM: synchronous write, registered read address.
module ae18_sram
   import ae18_pkg::*;
#(
   parameter int unsigned ISIZ = 21,
   parameter int unsigned SSIZ = 5
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [SSIZ-1:0] i_waddr,
   input  logic [ISIZ-1:0] i_wdata,
   input  logic            i_re,
   input  logic [SSIZ-1:0] i_raddr,
   output logic [ISIZ-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << SSIZ;

   logic [ISIZ-1:0] r_mem [DEPTH];
   logic [SSIZ-1:0] r_raddr;

   // Storage and read-address register; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_raddr <= i_raddr;
      end
   end

   assign o_rdata = r_mem[r_raddr];

endmodule : ae18_sram

// File: rtl/ae18_stack.sv
// Hardware stack: TOS kept in a register, deeper entries in ae18_sram.
module ae18_stack
   import ae18_pkg::*;
#(
   parameter int unsigned ISIZ = 21,
   parameter int unsigned SSIZ = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [ISIZ-1:0] din,
   input  logic            clr,
   output logic [ISIZ-1:0] tos,
   output logic            ready,
   output logic [SSIZ:0]   level,
   output logic            full,
   output logic            empty,
   output logic            ovf,
   output logic            unf
);

   localparam int unsigned   DEPTH    = 1 << SSIZ;
   localparam logic [SSIZ:0] LVL_FULL = (SSIZ + 1)'(DEPTH);
   localparam logic [SSIZ:0] LVL_ONE  = (SSIZ + 1)'(1);
   localparam logic [SSIZ:0] LVL_TWO  = (SSIZ + 1)'(2);

   ae18_stack_state_e r_state, w_state_nxt;
   logic [ISIZ-1:0]   r_tos, w_tos_nxt;
   logic [SSIZ:0]     r_level, w_level_nxt;
   logic              r_ovf, r_unf;
   logic              w_ovf_evt, w_unf_evt;
   logic              w_full, w_empty;
   logic [SSIZ:0]     w_lvl_m1, w_lvl_m2;
   logic              w_we, w_re;
   logic [ISIZ-1:0]   w_rdata;

   assign w_full   = (r_level == LVL_FULL);
   assign w_empty  = (r_level == '0);
   assign w_lvl_m1 = r_level - LVL_ONE;
   assign w_lvl_m2 = r_level - LVL_TWO;

   // RAM holds entries below TOS; old TOS spills to level-1, refill reads level-2.
   ae18_sram #(
      .ISIZ (ISIZ),
      .SSIZ (SSIZ)
   ) u_sram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_lvl_m1[SSIZ-1:0]),
      .i_wdata (r_tos),
      .i_re    (w_re),
      .i_raddr (w_lvl_m2[SSIZ-1:0]),
      .o_rdata (w_rdata)
   );

   // Next-state decode for push/pop; requests are ignored outside IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_tos_nxt   = r_tos;
      w_level_nxt = r_level;
      w_ovf_evt   = 1'b0;
      w_unf_evt   = 1'b0;
      w_we        = 1'b0;
      w_re        = 1'b0;
      case (r_state)
         StIdle: begin
            if (push && !pop) begin
               if (w_full) begin
                  w_ovf_evt = 1'b1;
               end else begin
                  w_we        = !w_empty;
                  w_tos_nxt   = din;
                  w_level_nxt = r_level + LVL_ONE;
               end
            end else if (pop && !push) begin
               if (r_level >= LVL_TWO) begin
                  w_re        = 1'b1;
                  w_level_nxt = w_lvl_m1;
                  w_state_nxt = StPopRd;
               end else if (r_level == LVL_ONE) begin
                  w_tos_nxt   = '0;
                  w_level_nxt = '0;
               end else begin
                  w_unf_evt = 1'b1;
               end
            end else if (push && pop) begin
               // Replace TOS in place; on empty this degenerates to a push plus underflow.
               w_tos_nxt = din;
               if (w_empty) begin
                  w_level_nxt = LVL_ONE;
                  w_unf_evt   = 1'b1;
               end
            end
         end
         StPopRd: begin
            w_tos_nxt   = w_rdata;
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State, TOS, level and sticky flags; a same-cycle event beats clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_tos   <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tos   <= w_tos_nxt;
         r_level <= w_level_nxt;
         r_ovf   <= (r_ovf & ~clr) | w_ovf_evt;
         r_unf   <= (r_unf & ~clr) | w_unf_evt;
      end
   end

   assign tos   = r_tos;
   assign ready = (r_state == StIdle);
   assign level = r_level;
   assign full  = w_full;
   assign empty = w_empty;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule : ae18_stack

// File: tb/tb_ae18_stack.sv
// Directed scoreboard bench for ae18_stack with ISIZ=8, SSIZ=2.
module tb_ae18_stack;

   logic       clk;
   logic       rst_n;
   logic       push_i;
   logic       pop_i;
   logic [7:0] din_i;
   logic       clr_i;
   logic [7:0] tos_o;
   logic       ready_o;
   logic [2:0] level_o;
   logic       full_o;
   logic       empty_o;
   logic       ovf_o;
   logic       unf_o;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string      tag;
      logic [7:0] tos;
      logic [2:0] lvl;
      logic       rdy;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t exp_q[$];

   ae18_stack #(
      .ISIZ (8),
      .SSIZ (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_i),
      .pop   (pop_i),
      .din   (din_i),
      .clr   (clr_i),
      .tos   (tos_o),
      .ready (ready_o),
      .level (level_o),
      .full  (full_o),
      .empty (empty_o),
      .ovf   (ovf_o),
      .unf   (unf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [7:0] t, input logic [2:0] l,
                            input logic r, input logic o, input logic u);
      exp_t e;
      e.tag   = tag;
      e.tos   = t;
      e.lvl   = l;
      e.rdy   = r;
      e.full  = (l == 3'd4);
      e.empty = (l == 3'd0);
      e.ovf   = o;
      e.unf   = u;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_err++;
         $error("FAIL scoreboard obs=empty exp=entry");
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, ".tos"},   tos_o,            e.tos);
         chk({e.tag, ".level"}, {5'b0, level_o},  {5'b0, e.lvl});
         chk({e.tag, ".ready"}, {7'b0, ready_o},  {7'b0, e.rdy});
         chk({e.tag, ".full"},  {7'b0, full_o},   {7'b0, e.full});
         chk({e.tag, ".empty"}, {7'b0, empty_o},  {7'b0, e.empty});
         chk({e.tag, ".ovf"},   {7'b0, ovf_o},    {7'b0, e.ovf});
         chk({e.tag, ".unf"},   {7'b0, unf_o},    {7'b0, e.unf});
      end
   endtask

   // One clock of stimulus; inputs change #1 after the edge, outputs sampled there too.
   task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c,
                       input string tag, input logic [7:0] et, input logic [2:0] el,
                       input logic er, input logic eo, input logic eu);
      push_i = p;
      pop_i  = q;
      din_i  = d;
      clr_i  = c;
      expect_st(tag, et, el, er, eo, eu);
      @(posedge clk);
      #1;
      push_i = 1'b0;
      pop_i  = 1'b0;
      din_i  = 8'h00;
      clr_i  = 1'b0;
      compare_out();
   endtask

   initial begin
      rst_n  = 1'b0;
      push_i = 1'b0;
      pop_i  = 1'b0;
      din_i  = 8'h00;
      clr_i  = 1'b0;
      #2;
      expect_st("reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
      compare_out();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      //   push  pop   din    clr   tag          tos    lvl   rdy   ovf   unf
      step(1'b1, 1'b0, 8'h11, 1'b0, "push11",    8'h11, 3'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h22, 1'b0, "push22",    8'h22, 3'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h33, 1'b0, "push33",    8'h33, 3'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h44, 1'b0, "push44",    8'h44, 3'd4, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h55, 1'b0, "ovf55",     8'h44, 3'd4, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h66, 1'b1, "ovf_clr",   8'h44, 3'd4, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, "clr_ovf",   8'h44, 3'd4, 1'b1, 1'b0, 1'b0);

      step(1'b0, 1'b1, 8'h00, 1'b0, "pop4_rd",   8'h44, 3'd3, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, "pop4_tos",  8'h33, 3'd3, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, "pop3_rd",   8'h33, 3'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hEE, 1'b0, "ign_busy",  8'h22, 3'd2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, "pop2_rd",   8'h22, 3'd1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, "pop2_tos",  8'h11, 3'd1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, "pop1",      8'h00, 3'd0, 1'b1, 1'b0, 1'b0);

      step(1'b0, 1'b1, 8'h00, 1'b0, "unf_pop",   8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b1, "unf_clr",   8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, "clr_unf",   8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b0, "pp_empty",  8'h77, 3'd1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, "clr_unf2",  8'h77, 3'd1, 1'b1, 1'b0, 1'b0);

      step(1'b0, 1'b1, 8'h00, 1'b0, "pop77",     8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h11, 1'b0, "re_push11", 8'h11, 3'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h22, 1'b0, "re_push22", 8'h22, 3'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b0, "pp_replace",8'h99, 3'd2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, "pop99_rd",  8'h99, 3'd1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, "pop99_tos", 8'h11, 3'd1, 1'b1, 1'b0, 1'b0);

      step(1'b1, 1'b0, 8'h22, 1'b0, "push22b",   8'h22, 3'd2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, "pop_abort", 8'h22, 3'd1, 1'b0, 1'b0, 1'b0);

      // Reset asserted while the refill read is in flight.
      rst_n = 1'b0;
      #1;
      expect_st("rst_mid", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
      compare_out();
      @(posedge clk);
      #1;
      expect_st("rst_hold", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
      compare_out();
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'hA5, 1'b0, "pushA5",    8'hA5, 3'd1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, "popA5",     8'h00, 3'd0, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_ae18_stack

// File: doc/ae18_stack.md
AE18_STACK -- requirements
Module: ae18_stack

Interface
REQ-001 Parameter ISIZ, default 21: entry width in bits.
REQ-002 Parameter SSIZ, default 5: depth exponent; DEPTH = 2^SSIZ entries in total, including TOS.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 push  input  1  push request; sampled only while ready=1.
REQ-006 pop  input  1  pop request; sampled only while ready=1.
REQ-007 din  input  ISIZ  data pushed.
REQ-008 clr  input  1  clears the sticky ovf and unf flags.
REQ-009 tos  output  ISIZ  registered top-of-stack value.
REQ-010 ready  output  1  block accepts push/pop this cycle.
REQ-011 level  output  SSIZ+1  number of valid entries, 0..DEPTH.
REQ-012 full / empty  output  1 each  level==DEPTH / level==0, combinational from level.
REQ-013 ovf / unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-014 TOS SHALL be held in a register; entries below TOS SHALL be held in RAM at addresses 0..level-2.
REQ-015 State machine SHALL have two states: IDLE (ready=1) and POPRD (ready=0).
REQ-016 Push only, not full, in IDLE: if level>0, write tos to RAM[level-1]; tos<=din; level+1; stay IDLE; single cycle.
REQ-017 Push only, full: no state change except ovf<=1.
REQ-018 Pop only, level>=2, in IDLE: RAM read address level-2 registered; level-1; go to POPRD.
REQ-019 In POPRD: tos<=RAM read data; return to IDLE; tos valid 2 cycles after pop accepted.
REQ-020 Pop only, level==1: tos<=0; level<=0; stay IDLE; single cycle.
REQ-021 Pop only, empty: unf<=1; tos and level unchanged.
REQ-022 Push and pop together, level>=1: tos<=din; level unchanged; no RAM access.
REQ-023 Push and pop together, empty: perform push as REQ-016 and set unf<=1.
REQ-024 push/pop while ready=0 SHALL be ignored and SHALL NOT set flags.
REQ-025 clr SHALL clear ovf and unf next edge; a same-cycle overflow or underflow event SHALL win over clr.
REQ-026 RAM read and write SHALL never target the same address in one cycle; no bypass is required.

Reset
REQ-027 On rst_n low, immediately: tos=0, level=0, ovf=0, unf=0, state=IDLE (ready=1).
REQ-028 Reset mid-POPRD SHALL abort the pop with no tos update; RAM contents are not reset.

Structure
REQ-029 State encodings (IDLE, POPRD) SHALL live as constants in the shared ae18 defines file.
REQ-030 Storage SHALL be one ae18_sram instance with its ISIZ and SSIZ set to this block's ISIZ and SSIZ; no other sub-modules.

Verification
Use ISIZ=8, SSIZ=2 (DEPTH=4) for all scenarios.
REQ-031 After reset, push 0x11,0x22,0x33,0x44 -> tos=0x44, level=4, full=1, ovf=0.
REQ-032 Full, push 0x55 -> level=4, tos=0x44, ovf=1; then clr -> ovf=0.
REQ-033 From 4 entries, pop -> ready=0 for 1 cycle, then tos=0x33, level=3; repeat pops -> 0x22, 0x11, then 0x00 with level=0 in a single cycle.
REQ-034 Empty, pop -> unf=1, level=0; empty, push+pop with din=0x77 -> tos=0x77, level=1, unf=1.
REQ-035 level=2 with tos=0x22, push+pop din=0x99 -> tos=0x99, level=2; then pop -> tos=0x11.
REQ-036 Assert rst_n low during POPRD -> outputs immediately at reset values; after release, push 0xA5 -> tos=0xA5, level=1.
